// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    SETTLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kp_state_t;

  localparam int unsigned SYNC_LAT  = 2;
  localparam logic [3:0]  COL_RESET = 4'b1000;

  // Bit position of the set bit in a one-hot nibble.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/kp_debounce_cnt.sv
// Saturating debounce counter: counts stable samples, flags when DB_CYCLES reached.
module kp_debounce_cnt #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int unsigned W     = $clog2(DB_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(DB_CYCLES);

  logic [W-1:0] count;

  // Counter register: clear wins over increment, holds once the limit is hit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count < LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign done = (count >= LIMIT);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates a one-hot column drive, locks onto a single
// conducting key, debounces press and release, and reports the key code.
module keypad_scan_ctrl #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned SYNC_LAT  = keypad_pkg::SYNC_LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r,
  output logic [3:0] cHigh,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int unsigned SW = (SYNC_LAT > 1) ? $clog2(SYNC_LAT) : 1;

  kp_state_t     state, next_state;
  logic [3:0]    col_hist [SYNC_LAT];
  logic [3:0]    col_d;
  logic [3:0]    row_lat;
  logic [SW-1:0] settle_cnt;
  logic          settle_last;
  logic          detect;
  logic          cnt_clr, cnt_inc, cnt_done;

  assign col_d       = col_hist[SYNC_LAT-1];
  assign settle_last = (settle_cnt == SW'(SYNC_LAT - 1));
  assign detect      = is_onehot(r) && (col_d != '0);

  kp_debounce_cnt #(.DB_CYCLES(DB_CYCLES)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clr),
    .inc  (cnt_inc),
    .done (cnt_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      SCAN:     if (detect) next_state = SETTLE;
      SETTLE:   if (settle_last) next_state = PRESS_DB;
      PRESS_DB: begin
        if (cnt_done)          next_state = HELD;
        else if (r != row_lat) next_state = SCAN;
      end
      HELD:     if (r != row_lat) next_state = REL_DB;
      REL_DB: begin
        if (cnt_done)                  next_state = SCAN;
        else if ((r & row_lat) != '0)  next_state = HELD;
      end
      default:  next_state = SCAN;
    endcase
  end

  // Moore outputs and debounce counter control; the counter is held clear
  // outside the two debounce states so each debounce starts from zero.
  always_comb begin
    key_held = (state == HELD) || (state == REL_DB);
    cnt_clr  = (state != PRESS_DB) && (state != REL_DB);
    cnt_inc  = ((state == PRESS_DB) && (r == row_lat)) ||
               ((state == REL_DB) && ((r & row_lat) == '0));
  end

  // Datapath: column drive, column history, latched row, settle timer, key report.
  // cHigh only moves in SCAN, so leaving any other state resumes rotation from
  // the latched column.
  always_ff @(posedge clk) begin
    if (reset) begin
      cHigh      <= COL_RESET;
      row_lat    <= '0;
      settle_cnt <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      for (int unsigned i = 0; i < SYNC_LAT; i++) col_hist[i] <= '0;
    end else begin
      col_hist[0] <= cHigh;
      for (int unsigned i = 1; i < SYNC_LAT; i++) col_hist[i] <= col_hist[i-1];

      if (state == SCAN) begin
        if (detect) begin
          cHigh   <= col_d;
          row_lat <= r;
        end else begin
          cHigh <= {cHigh[0], cHigh[3:1]};
        end
      end

      if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
      else                 settle_cnt <= '0;

      key_valid <= (state == PRESS_DB) && cnt_done;
      if ((state == PRESS_DB) && cnt_done) begin
        key_code <= {onehot_idx(row_lat), onehot_idx(cHigh)};
      end
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001: Parameter DB_CYCLES, default 16, consecutive stable samples required for press/release debounce; legal range 1..65535.
REQ-002: Parameter SYNC_LAT, default 2, row synchronizer latency in cycles; fixed at 2 for this release.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: r  input  4  synchronized row bits; r[i]=1 means row i conducting.
REQ-006: cHigh  output  4  one-hot column drive to keypad.
REQ-007: key_code  output  4  code of last debounced key = 4*row_idx + col_idx (col_idx = bit position of cHigh).
REQ-008: key_valid  output  1  one-cycle pulse when key_code is updated.
REQ-009: key_held  output  1  high while a debounced key is held (states HELD, REL_DB).

Function
REQ-010: The FSM SHALL have states SCAN, SETTLE, PRESS_DB, HELD, REL_DB.
REQ-011: In SCAN, cHigh SHALL rotate right each cycle (1000->0100->0010->0001->1000).
REQ-012: A SYNC_LAT-deep column history SHALL pair each r sample with the cHigh value driven SYNC_LAT cycles earlier (col_d).
REQ-013: In SCAN, when r is one-hot and col_d is nonzero, the block SHALL latch row=r and col=col_d, drive cHigh=col from the next cycle, and enter SETTLE.
REQ-014: In SCAN, r with zero bits or more than one bit set SHALL be ignored; rotation continues.
REQ-015: SETTLE SHALL last exactly SYNC_LAT cycles, ignore r, then enter PRESS_DB with counter cleared.
REQ-016: In PRESS_DB, each cycle with r==latched row SHALL increment the counter; any other r SHALL return to SCAN, with rotation resuming from the latched column.
REQ-017: When the counter reaches DB_CYCLES, the block SHALL update key_code, assert key_valid for exactly one cycle, and enter HELD.
REQ-018: In HELD, cHigh SHALL stay at the latched column; r==latched row keeps HELD; any other r enters REL_DB with counter cleared.
REQ-019: In REL_DB, each cycle with latched row bit 0 SHALL increment the counter; latched row bit 1 SHALL return to HELD with no new key_valid.
REQ-020: When the REL_DB counter reaches DB_CYCLES, the block SHALL enter SCAN, rotating from the latched column.
REQ-021: key_code SHALL hold its value between key_valid pulses; a second key pressed while HELD SHALL be ignored.
REQ-022: The counter SHALL be $clog2(DB_CYCLES+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-023: When reset is asserted, the block SHALL set cHigh=4'b1000, key_code=0, key_valid=0, key_held=0, counter=0, column history=0, and state SCAN on the next edge.
REQ-024: Reset asserted in any state, including mid-debounce, SHALL abort the operation with no key_valid pulse; reset SHALL take priority over all transitions.

Structure
REQ-025: Package keypad_pkg SHALL hold the state enum, SYNC_LAT, COL_RESET=4'b1000, and a function for the one-hot-to-index conversion.
REQ-026: Debounce counting SHALL be implemented in one sub-module, kp_debounce_cnt (clear, inc, done = count>=DB_CYCLES).

Verification (DB_CYCLES=4)
REQ-027: Reset, r=0 for 12 cycles -> cHigh cycles 1000,0100,0010,0001 repeatedly; key_valid never asserts.
REQ-028: r=0100 presented whenever col_d=0010 and held stable -> cHigh frozen at 0010, one key_valid pulse after SYNC_LAT+4 cycles, key_code=4*2+1=9, key_held=1.
REQ-029: Press with r bouncing to 0 on the 2nd PRESS_DB cycle -> return to SCAN, no key_valid.
REQ-030: HELD key, r drops to 0 for 2 cycles then returns -> stays HELD, no second pulse; r=0 for 4 cycles -> SCAN, key_held=0.
REQ-031: r=0011 during SCAN -> ignored; reset asserted during PRESS_DB -> cHigh=1000, key_valid=0 next cycle.
